// File: rtl/fetch_unit_param.sv
// ---------------------------------------------------------------------------
// fetch_unit_param
//
// Purpose:
//   Parametrised fetch stage. Each cycle it issues a FETCH_WIDTH-instruction
//   bundle request to the multi-line icache as NUM_LINES line requests. The
//   response arrives one cycle later. When every line hits, the IB has room
//   for a whole bundle and no redirect is present, the bundle goes to the
//   instruction buffer.
//
//   Delivered bundles have a lane mask. Lanes below the start lane of an
//   unaligned PC are masked off. Lanes after a predicted-taken branch are
//   also masked off. The first branch in the bundle is sent to the branch
//   predictor in the same cycle, and the answer selects the next fetch PC.
//
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   read_addrs       per-line icache requests (valid + line address)
//   cache_data       per-line icache responses, one cycle after request
//   ib_free_slots    free entries in the instruction buffer this cycle
//   ib_bundle_valid  fetch_packet carries a real bundle
//   fetch_packet     per-lane pc, instruction, valid and branch metadata
//   bp_request       branch predictor query for the first branch lane
//   bp_response      same-cycle branch predictor answer
//   redirect_valid   pipeline redirect (mispredict / exception)
//   redirect_pc      exact restart PC for a redirect
//   fetch_pc_dbg     PC of the request currently outstanding
//   bundle_cnt       bundles delivered (wraps)
//   stall_cnt        cycles with a request outstanding but nothing delivered
// ---------------------------------------------------------------------------
package fetch_unit_param_pkg;

   // The icache line type carries DEF_LINE_WORDS words. The LINE_WORDS
   // parameter of the fetch unit must match this value.
   localparam int DEF_LINE_WORDS = 2;
   localparam int GHR_W = 8;
   localparam logic [6:0] RV32_BRANCH = 7'b1100011;

   typedef logic [31:0] addr_t;

   typedef struct packed {
      logic  valid;
      addr_t addr;
   } i_addr_packet_t;

   typedef struct packed {
      logic [DEF_LINE_WORDS-1:0][31:0] word_level;
   } cache_line_t;

   typedef struct packed {
      logic        valid;
      cache_line_t data;
   } cache_data_t;

   typedef struct packed {
      logic  valid;
      addr_t pc;
   } bp_predict_request_t;

   typedef struct packed {
      logic             taken;
      addr_t            target;
      logic [GHR_W-1:0] ghr_snapshot;
   } bp_predict_response_t;

   typedef struct packed {
      logic             valid;
      addr_t            pc;
      logic [31:0]      inst;
      logic             is_branch;
      logic             taken;
      addr_t            target;
      logic [GHR_W-1:0] ghr_snapshot;
   } fetch_packet_t;

endpackage

module fetch_unit_param
   import fetch_unit_param_pkg::*;
#(
   parameter int          FETCH_WIDTH = 4,
   parameter int          LINE_WORDS  = DEF_LINE_WORDS,
   parameter int          NUM_LINES   = FETCH_WIDTH / LINE_WORDS,
   parameter int          IB_CREDIT_W = 4,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          CNT_W       = 32
) (
   input  logic                                   clock,
   input  logic                                   reset_n,
   output i_addr_packet_t       [NUM_LINES-1:0]   read_addrs,
   input  cache_data_t          [NUM_LINES-1:0]   cache_data,
   input  logic                 [IB_CREDIT_W-1:0] ib_free_slots,
   output logic                                   ib_bundle_valid,
   output fetch_packet_t        [FETCH_WIDTH-1:0] fetch_packet,
   output bp_predict_request_t                    bp_request,
   input  bp_predict_response_t                   bp_response,
   input  logic                                   redirect_valid,
   input  addr_t                                  redirect_pc,
   output addr_t                                  fetch_pc_dbg,
   output logic                 [CNT_W-1:0]       bundle_cnt,
   output logic                 [CNT_W-1:0]       stall_cnt
);

   localparam int    LANE_W       = $clog2(FETCH_WIDTH);
   localparam int    OFF_W        = LANE_W + 2;
   localparam addr_t BUNDLE_BYTES = addr_t'(4 * FETCH_WIDTH);
   localparam addr_t LINE_BYTES   = addr_t'(4 * LINE_WORDS);

   addr_t             req_pc_q, req_pc_d;
   logic              req_v_q, req_v_d;
   logic [CNT_W-1:0]  bundle_cnt_q, bundle_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   addr_t             base;
   logic [LANE_W-1:0] start_lane;
   addr_t             lane_pc   [FETCH_WIDTH];
   logic [31:0]       lane_inst [FETCH_WIDTH];
   logic              all_hit, credits_ok, resp_ok;
   logic              br_found, taken;
   logic [LANE_W-1:0] br_lane;
   logic              issue;
   addr_t             issue_pc, issue_base;

   // Split the outstanding request into a bundle base and a start lane.
   // Then decide whether the response that arrives now can be delivered.
   // The branch scan goes downward so that the lowest eligible branch lane
   // is the last one written.
   always_comb begin
      base       = {req_pc_q[31:OFF_W], {OFF_W{1'b0}}};
      start_lane = req_pc_q[OFF_W-1:2];
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         lane_pc[k]   = base + addr_t'(4 * k);
         lane_inst[k] = cache_data[k / LINE_WORDS].data.word_level[k % LINE_WORDS];
      end
      all_hit = 1'b1;
      for (int i = 0; i < NUM_LINES; i++) begin
         all_hit = all_hit & cache_data[i].valid;
      end
      credits_ok = int'(ib_free_slots) >= FETCH_WIDTH;
      resp_ok    = req_v_q && all_hit && credits_ok && !redirect_valid;
      br_found   = 1'b0;
      br_lane    = '0;
      for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
         if (k >= int'(start_lane) && lane_inst[k][6:0] == RV32_BRANCH) begin
            br_found = 1'b1;
            br_lane  = LANE_W'(k);
         end
      end
      taken = br_found && bp_response.taken;
   end

   // Next request selection. A redirect cancels everything, including a
   // response that would otherwise be deliverable. The restart PC is only
   // loaded in that cycle and is issued in the next one. A miss or a lack
   // of credits reissues the same bundle until it can be delivered.
   always_comb begin
      req_pc_d = req_pc_q;
      req_v_d  = req_v_q;
      issue    = 1'b0;
      issue_pc = req_pc_q;
      if (redirect_valid) begin
         req_pc_d = redirect_pc & ~addr_t'(3);
         req_v_d  = 1'b0;
      end else if (!req_v_q) begin
         issue   = 1'b1;
         req_v_d = 1'b1;
      end else if (resp_ok) begin
         issue    = 1'b1;
         issue_pc = taken ? bp_response.target : base + BUNDLE_BYTES;
         req_pc_d = issue_pc;
      end else begin
         issue = 1'b1;
      end
      issue_base   = {issue_pc[31:OFF_W], {OFF_W{1'b0}}};
      bundle_cnt_d = bundle_cnt_q + CNT_W'(resp_ok);
      stall_cnt_d  = stall_cnt_q + CNT_W'(req_v_q && !resp_ok && !redirect_valid);
   end

   // Drive the icache, predictor and IB outputs. Every output is forced to
   // zero while reset_n is low. Without this, the "issue at req_pc_q when
   // idle" path would drive live requests while reset is held.
   always_comb begin
      for (int i = 0; i < NUM_LINES; i++) begin
         read_addrs[i].valid = issue && reset_n;
         read_addrs[i].addr  = reset_n ? issue_base + LINE_BYTES * addr_t'(i) : '0;
      end
      ib_bundle_valid = resp_ok;
      bp_request      = '0;
      if (resp_ok && br_found) begin
         bp_request.valid = 1'b1;
         bp_request.pc    = lane_pc[br_lane];
      end
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         fetch_packet[k] = '0;
         if (reset_n) begin
            fetch_packet[k].pc   = lane_pc[k];
            fetch_packet[k].inst = lane_inst[k];
         end
         fetch_packet[k].valid = resp_ok && (k >= int'(start_lane)) &&
                                 (!taken || k <= int'(br_lane));
         if (reset_n && br_found && LANE_W'(k) == br_lane) begin
            fetch_packet[k].is_branch    = 1'b1;
            fetch_packet[k].taken        = bp_response.taken;
            fetch_packet[k].target       = bp_response.target;
            fetch_packet[k].ghr_snapshot = bp_response.ghr_snapshot;
         end
      end
      fetch_pc_dbg = reset_n ? req_pc_q : '0;
      bundle_cnt   = bundle_cnt_q;
      stall_cnt    = stall_cnt_q;
   end

   // Request PC, outstanding flag and performance counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_pc_q     <= RESET_PC;
         req_v_q      <= 1'b0;
         bundle_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         req_pc_q     <= req_pc_d;
         req_v_q      <= req_v_d;
         bundle_cnt_q <= bundle_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit_param.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit_param
//
// This bench surrounds fetch_unit_param with two pieces:
//   - An icache stand-in. It answers each captured request one cycle later
//     with words from a fixed pseudo-random instruction memory.
//   - A reference model. It tracks the outstanding fetch PC, the expected
//     bundle contents and the counters.
// The model reads instructions straight from the memory function, so it
// does not depend on how the DUT maps lanes onto icache lines.
// ---------------------------------------------------------------------------
module tb_fetch_unit_param;
   import fetch_unit_param_pkg::*;

   localparam int          FW       = 4;
   localparam int          LW       = 2;
   localparam int          NL       = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic                          clock = 1'b0;
   logic                          reset_n;
   i_addr_packet_t       [NL-1:0] read_addrs;
   cache_data_t          [NL-1:0] cache_data;
   logic                 [3:0]    ib_free_slots;
   logic                          ib_bundle_valid;
   fetch_packet_t        [FW-1:0] fetch_packet;
   bp_predict_request_t           bp_request;
   bp_predict_response_t          bp_response;
   logic                          redirect_valid;
   logic                 [31:0]   redirect_pc;
   logic                 [31:0]   fetch_pc_dbg;
   logic                 [31:0]   bundle_cnt;
   logic                 [31:0]   stall_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] mPc;
   bit          mValid;
   int unsigned mBundles;
   int unsigned mStalls;
   logic [31:0] capAddr [NL];
   bit          capValid;

   fetch_unit_param #(
      .FETCH_WIDTH (FW),
      .LINE_WORDS  (LW),
      .NUM_LINES   (NL),
      .IB_CREDIT_W (4),
      .RESET_PC    (RESET_PC),
      .CNT_W       (32)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .read_addrs      (read_addrs),
      .cache_data      (cache_data),
      .ib_free_slots   (ib_free_slots),
      .ib_bundle_valid (ib_bundle_valid),
      .fetch_packet    (fetch_packet),
      .bp_request      (bp_request),
      .bp_response     (bp_response),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .fetch_pc_dbg    (fetch_pc_dbg),
      .bundle_cnt      (bundle_cnt),
      .stall_cnt       (stall_cnt)
   );

   // 10 ns free-running clock.
   always #5 clock = ~clock;

   // Instruction memory. Every word whose word index is 3 mod 7 is a
   // conditional branch, which puts a branch in lane 1 of the 0x40 bundle.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      logic [31:0] h;
      h = addr * 32'h9E3779B1 + 32'h01234567;
      if (((addr >> 2) % 7) == 3) return {h[31:7], 7'h63};
      return {h[31:7], 7'h13};
   endfunction

   function automatic bit isBranchAt(input logic [31:0] addr);
      logic [31:0] w;
      w = memWord(addr);
      return w[6:0] == 7'h63;
   endfunction

   // One comparison, with an immediate assertion.
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mPc      = RESET_PC;
      mValid   = 1'b0;
      mBundles = 0;
      mStalls  = 0;
      capValid = 1'b0;
   endtask

   // All DUT outputs must read as zero while reset is asserted.
   task automatic checkResetOutputs();
      checkOutput("rst_ib_bundle_valid", ib_bundle_valid, 0);
      for (int i = 0; i < NL; i++) begin
         checkOutput($sformatf("rst_read_addrs[%0d]", i), read_addrs[i], 0);
      end
      checkOutput("rst_bp_request", bp_request, 0);
      for (int k = 0; k < FW; k++) begin
         checkOutput($sformatf("rst_fetch_packet[%0d]", k), fetch_packet[k], 0);
      end
      checkOutput("rst_fetch_pc_dbg", fetch_pc_dbg, 0);
      checkOutput("rst_bundle_cnt", bundle_cnt, 0);
      checkOutput("rst_stall_cnt", stall_cnt, 0);
   endtask

   // One clock cycle. The task drives the inputs, checks every output
   // against the model at the falling edge, records the DUT's request for
   // the icache stand-in, and advances the model at the rising edge.
   task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input logic [3:0] free,
                                input logic [1:0] hitMask, input bit tk, input logic [31:0] tgt);
      logic [31:0] base, issuePc, laneAddr;
      logic [7:0]  ghr;
      int          start, brLane;
      bit          respOk, expTaken, expIssue, laneV;

      ghr            = 8'($urandom);
      redirect_valid = redir;
      redirect_pc    = rpc;
      ib_free_slots  = free;
      for (int i = 0; i < NL; i++) begin
         cache_data[i].valid = hitMask[i];
         for (int j = 0; j < LW; j++) begin
            cache_data[i].data.word_level[j] = capValid ? memWord(capAddr[i] + 32'(4 * j)) : $urandom;
         end
      end
      bp_response.taken        = tk;
      bp_response.target       = tgt;
      bp_response.ghr_snapshot = ghr;

      base     = mPc & ~32'hF;
      start    = int'((mPc >> 2) % 4);
      respOk   = mValid && (hitMask == 2'b11) && (free >= 4) && !redir;
      brLane   = -1;
      for (int k = start; k < FW; k++) begin
         if (brLane < 0 && isBranchAt(base + 32'(4 * k))) brLane = k;
      end
      expTaken = (brLane >= 0) && tk;
      expIssue = !redir;
      if (!mValid || !respOk) issuePc = mPc;
      else issuePc = expTaken ? tgt : base + 32'd16;

      @(negedge clock);
      checkOutput("ib_bundle_valid", ib_bundle_valid, respOk);
      checkOutput("fetch_pc_dbg", fetch_pc_dbg, mPc);
      checkOutput("bundle_cnt", bundle_cnt, mBundles);
      checkOutput("stall_cnt", stall_cnt, mStalls);
      for (int i = 0; i < NL; i++) begin
         checkOutput($sformatf("read_valid[%0d]", i), read_addrs[i].valid, expIssue);
         if (expIssue) begin
            checkOutput($sformatf("read_addr[%0d]", i), read_addrs[i].addr,
                        (issuePc & ~32'hF) + 32'(8 * i));
         end
      end
      checkOutput("bp_req_valid", bp_request.valid, respOk && brLane >= 0);
      if (respOk && brLane >= 0) begin
         checkOutput("bp_req_pc", bp_request.pc, base + 32'(4 * brLane));
      end
      for (int k = 0; k < FW; k++) begin
         laneAddr = base + 32'(4 * k);
         laneV    = respOk && k >= start && (!expTaken || k <= brLane);
         checkOutput($sformatf("lane_valid[%0d]", k), fetch_packet[k].valid, laneV);
         checkOutput($sformatf("lane_pc[%0d]", k), fetch_packet[k].pc, laneAddr);
         if (respOk) begin
            checkOutput($sformatf("lane_inst[%0d]", k), fetch_packet[k].inst, memWord(laneAddr));
            checkOutput($sformatf("lane_is_branch[%0d]", k), fetch_packet[k].is_branch, k == brLane);
            if (k == brLane) begin
               checkOutput($sformatf("lane_taken[%0d]", k), fetch_packet[k].taken, tk);
               checkOutput($sformatf("lane_target[%0d]", k), fetch_packet[k].target, tgt);
               checkOutput($sformatf("lane_ghr[%0d]", k), fetch_packet[k].ghr_snapshot, ghr);
            end else begin
               checkOutput($sformatf("lane_meta[%0d]", k),
                           {fetch_packet[k].taken, fetch_packet[k].target, fetch_packet[k].ghr_snapshot}, 0);
            end
         end
      end
      capValid = read_addrs[0].valid;
      for (int i = 0; i < NL; i++) capAddr[i] = read_addrs[i].addr;

      @(posedge clock);
      if (respOk) mBundles++;
      if (mValid && !respOk && !redir) mStalls++;
      if (redir) begin
         mPc    = rpc & ~32'h3;
         mValid = 1'b0;
      end else if (!mValid) begin
         mValid = 1'b1;
      end else if (respOk) begin
         mPc = issuePc;
      end
      #1;
   endtask

   // Directed scenarios first, then a randomised stretch, then a reset in
   // the middle of the stream with a hit response still pending.
   initial begin
      bit          rRedir;
      logic [1:0]  rHit;

      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ib_free_slots  = 4'd8;
      cache_data     = '0;
      bp_response    = '0;
      modelReset();
      cache_data[0].valid = 1'b1;
      cache_data[1].valid = 1'b1;
      repeat (2) @(posedge clock);
      #1 redirect_valid = 1'b1;
      redirect_pc = 32'h80;
      #1 checkResetOutputs();
      redirect_valid = 1'b0;
      @(posedge clock);
      #1 reset_n = 1'b1;

      $display("[TB] straight-line hits from RESET_PC");
      repeat (5) applyStimulus(0, 0, 4'd8, 2'b11, 0, 0);

      $display("[TB] redirect to unaligned 0x24");
      applyStimulus(1, 32'h24, 4'd8, 2'b11, 0, 0);
      repeat (3) applyStimulus(0, 0, 4'd8, 2'b11, 0, 0);

      $display("[TB] taken branch in lane 1 of bundle 0x40");
      applyStimulus(1, 32'h40, 4'd8, 2'b11, 0, 0);
      applyStimulus(0, 0, 4'd8, 2'b11, 1, 32'h100);
      applyStimulus(0, 0, 4'd8, 2'b11, 1, 32'h100);
      repeat (2) applyStimulus(0, 0, 4'd8, 2'b11, 0, 0);

      $display("[TB] line 1 misses for three cycles");
      repeat (3) applyStimulus(0, 0, 4'd8, 2'b01, 0, 0);
      applyStimulus(0, 0, 4'd8, 2'b11, 0, 0);

      $display("[TB] IB credits 3 then 4");
      repeat (2) applyStimulus(0, 0, 4'd3, 2'b11, 0, 0);
      applyStimulus(0, 0, 4'd4, 2'b11, 0, 0);

      $display("[TB] redirect alongside a hit response");
      applyStimulus(1, 32'h203, 4'd8, 2'b11, 0, 0);
      repeat (3) applyStimulus(0, 0, 4'd8, 2'b11, 0, 0);

      $display("[TB] randomised traffic");
      for (int n = 0; n < 400; n++) begin
         rRedir = ($urandom_range(0, 9) == 0);
         rHit   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
         applyStimulus(rRedir, $urandom & 32'hFFF, 4'($urandom_range(2, 15)), rHit,
                       1'($urandom), $urandom & 32'hFFFC);
      end

      $display("[TB] reset asserted mid-stream");
      applyStimulus(0, 0, 4'd8, 2'b11, 0, 0);
      reset_n = 1'b0;
      modelReset();
      #1 checkResetOutputs();
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int n = 0; n < 30; n++) begin
         applyStimulus(0, 0, 4'($urandom_range(3, 15)), 2'b11, 1'($urandom), $urandom & 32'hFFFC);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
